id_serialize_stage: RTL
=======================

Name: id_serialize_stage

Overview:
- Parametrised successor of the decode-stage output register and its syscall bubble logic.
- Registers a decoded instruction bundle toward EXE and passes it through in normal operation.
- When a serialising instruction (syscall, LL/SC flush) arrives, it drains the pipe with a configurable number of bubbles, then pulses SYS to the simulator.
- Freeze and inhibit handshakes with fetch are generated here; drain length, SYS pulse width and bundle width are parameters rather than hard-coded.

Parameters:
- BUNDLE_W, 128: width of the decoded bundle (operands, regs, controls, instr, PC).
- DRAIN_CYCLES, 3: bubble cycles between capture and SYS; legal range 1..15.
- SYS_HOLD, 1: cycles SYS stays high; legal range 1..15.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- Bundle_IN  in  BUNDLE_W  decoded bundle from decoder/operand mux.
- Valid_IN  in  1  Bundle_IN holds a real instruction.
- Serialize_IN  in  1  instruction requires drain (syscall, LL, SC).
- Silent_IN  in  1  drain without SYS (LL/SC); sampled with Serialize_IN.
- Hold_IN  in  1  downstream stall; freezes all state.
- Bundle_OUT  out  BUNDLE_W  registered bundle to EXE.
- Valid_OUT  out  1  Bundle_OUT is a real instruction.
- Marker_OUT  out  1  serialising marker travelling to MEM (cache flush).
- SYS  out  1  tell simulator to process system call.
- WANT_FREEZE  out  1  fetch must hold PC (combinational).
- Busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (synchronous, RESET=1 at CLK edge) forces state IDLE with cnt=0, all registered outputs 0, and latched silent=0.
- Reset overrides any state, including mid-drain; SYS drops the next edge.
- Hold_IN=1 (and RESET=0): every register keeps its value, and WANT_FREEZE is still computed from the held state.
- IDLE, Valid_IN & Serialize_IN:
  - Bundle_OUT=0, Valid_OUT=0, Marker_OUT=1.
  - Latch silent<=Silent_IN; cnt<=DRAIN_CYCLES; go to DRAIN.
- IDLE, otherwise: Bundle_OUT<=Bundle_IN, Valid_OUT<=Valid_IN, Marker_OUT<=0. Pass-through latency is 1 cycle.
- DRAIN:
  - Outputs are bubbles (Bundle_OUT=0, Valid_OUT=0, Marker_OUT=0).
  - cnt decrements each edge.
  - When cnt==1: go to NOTIFY, SYS<=!silent, cnt<=SYS_HOLD.
  - DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- NOTIFY:
  - Outputs are bubbles; cnt decrements each edge.
  - When cnt==1: SYS<=0, go to RELEASE.
- RELEASE:
  - Bubbles for one cycle; the input is ignored (fetch is still presenting the serialising instruction); go to IDLE.
- WANT_FREEZE = (IDLE & Valid_IN & Serialize_IN) | DRAIN | NOTIFY.
  - It is forced low in RELEASE (inhibit), so fetch advances exactly once past the serialising instruction.
- Back-to-back serialising instructions:
  - The next one is only recognised in IDLE after RELEASE.
  - No overlap, and no SYS merge.
- Counter width is 4 bits. Parameter values outside the legal range are a $error at elaboration.
- Busy = (state != IDLE).

Optional Feature:
- Macro: ID_SERIALIZE_STATS_EN.
- When defined, adds two outputs, both reset to 0 by RESET and frozen by Hold_IN:
  - Serialize_Count[31:0]: increments on each IDLE->DRAIN transition.
  - Bubble_Count[31:0]: increments every cycle Valid_OUT is forced to 0 by the FSM (DRAIN, NOTIFY, RELEASE, and the capture cycle).
  - Both wrap modulo 2^32.
- When undefined, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Pass-through: Valid_IN=1, Serialize_IN=0, Bundle_IN=0xA5..A5 -> next cycle Bundle_OUT=0xA5..A5, Valid_OUT=1, WANT_FREEZE=0.
- Syscall, defaults (DRAIN_CYCLES=3, SYS_HOLD=1), Serialize_IN=1 and Silent_IN=0 at edge 0:
  - Marker_OUT=1 after edge 0.
  - 3 DRAIN cycles.
  - SYS=1 for exactly 1 cycle after edge 3.
  - RELEASE after edge 4 with WANT_FREEZE=0.
  - IDLE after edge 5.
  - WANT_FREEZE high cycles 0..3.
- LL/SC (Silent_IN=1): same timing as the syscall case; SYS never rises; Marker_OUT=1 on capture.
- Hold_IN=1 for 2 cycles mid-DRAIN (cnt=2): cnt and outputs unchanged during hold; SYS appears 2 cycles later than without hold.
- RESET=1 during NOTIFY with SYS=1: next edge SYS=0, Busy=0, Bundle_OUT=0, then pass-through resumes.
- Two consecutive syscalls with DRAIN_CYCLES=1, SYS_HOLD=2: two separate SYS pulses of 2 cycles each, separated by RELEASE plus a fresh capture; with ID_SERIALIZE_STATS_EN defined, Serialize_Count=2.

Source files
------------

// File: rtl/id_serialize_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_serialize_stage                                           |
// | Description : Decode-stage output register with serialising-instruction    |
// |               drain logic. Normal bundles pass through with one cycle of   |
// |               latency. A serialising instruction (syscall, LL/SC) is        |
// |               turned into a marker bubble. The pipe is then drained for     |
// |               DRAIN_CYCLES cycles, SYS is raised for SYS_HOLD cycles        |
// |               (suppressed for silent LL/SC), and fetch is released exactly  |
// |               once.                                                         |
// | Option      : define ID_SERIALIZE_STATS_EN to add the Serialize_Count and   |
// |               Bubble_Count statistics outputs.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module id_serialize_stage #(
  parameter int BUNDLE_W     = 128,
  parameter int DRAIN_CYCLES = 3,
  parameter int SYS_HOLD     = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [BUNDLE_W-1:0] Bundle_IN,
  input  logic                Valid_IN,
  input  logic                Serialize_IN,
  input  logic                Silent_IN,
  input  logic                Hold_IN,
  output logic [BUNDLE_W-1:0] Bundle_OUT,
  output logic                Valid_OUT,
  output logic                Marker_OUT,
  output logic                SYS,
  output logic                WANT_FREEZE,
  output logic                Busy
`ifdef ID_SERIALIZE_STATS_EN
  ,
  output logic [31:0]         Serialize_Count,
  output logic [31:0]         Bubble_Count
`endif
);

  // Counter reload values; both must fit the 4-bit counter.
  localparam logic [3:0] c_drain_ld = 4'(DRAIN_CYCLES);
  localparam logic [3:0] c_hold_ld  = 4'(SYS_HOLD);

  if ((DRAIN_CYCLES < 1) || (DRAIN_CYCLES > 15)) begin : g_bad_drain
    $error("id_serialize_stage: DRAIN_CYCLES must be in 1..15");
  end
  if ((SYS_HOLD < 1) || (SYS_HOLD > 15)) begin : g_bad_hold
    $error("id_serialize_stage: SYS_HOLD must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_NOTIFY  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                silent_q, silent_d;
  logic [BUNDLE_W-1:0] bundle_q, bundle_d;
  logic                valid_q, valid_d;
  logic                marker_q, marker_d;
  logic                sys_q, sys_d;
  logic                w_capture;
  logic                w_freeze;

  // A serialising instruction is only recognised while idle.
  assign w_capture = (state_q == S_IDLE) && Valid_IN && Serialize_IN;

  // Next-state, output-register and freeze decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    silent_d = silent_q;
    bundle_d = '0;
    valid_d  = 1'b0;
    marker_d = 1'b0;
    sys_d    = sys_q;
    w_freeze = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_capture) begin
          w_freeze = 1'b1;
          marker_d = 1'b1;
          silent_d = Silent_IN;
          cnt_d    = c_drain_ld;
          state_d  = S_DRAIN;
        end else begin
          bundle_d = Bundle_IN;
          valid_d  = Valid_IN;
        end
      end
      S_DRAIN: begin
        w_freeze = 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = S_NOTIFY;
          sys_d   = !silent_q;
          cnt_d   = c_hold_ld;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_NOTIFY: begin
        w_freeze = 1'b1;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          sys_d   = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Fetch still shows the serialising instruction; let it advance once.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over hold, hold freezes everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      silent_q <= 1'b0;
      bundle_q <= '0;
      valid_q  <= 1'b0;
      marker_q <= 1'b0;
      sys_q    <= 1'b0;
    end else if (!Hold_IN) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      silent_q <= silent_d;
      bundle_q <= bundle_d;
      valid_q  <= valid_d;
      marker_q <= marker_d;
      sys_q    <= sys_d;
    end
  end

  assign Bundle_OUT  = bundle_q;
  assign Valid_OUT   = valid_q;
  assign Marker_OUT  = marker_q;
  assign SYS         = sys_q;
  assign WANT_FREEZE = w_freeze;
  assign Busy        = (state_q != S_IDLE);

`ifdef ID_SERIALIZE_STATS_EN
  logic [31:0] ser_cnt_q;
  logic [31:0] bub_cnt_q;
  logic        w_forced_bubble;

  // The FSM forces a bubble on the capture edge and on every non-idle edge.
  assign w_forced_bubble = w_capture || (state_q != S_IDLE);

  // Statistics counters, wrapping modulo 2^32.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ser_cnt_q <= '0;
      bub_cnt_q <= '0;
    end else if (!Hold_IN) begin
      if (w_capture) begin
        ser_cnt_q <= ser_cnt_q + 32'd1;
      end
      if (w_forced_bubble) begin
        bub_cnt_q <= bub_cnt_q + 32'd1;
      end
    end
  end

  assign Serialize_Count = ser_cnt_q;
  assign Bubble_Count    = bub_cnt_q;
`endif

endmodule
`default_nettype wire
